// File: rtl/div32_iter.sv
// Iterative 32-bit restoring divider: signed/unsigned quotient or remainder,
// one quotient bit per clock, with divide-by-zero and signed-overflow shortcuts.
module div32_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           r_state, w_next;
  logic [4:0]       r_cnt;
  logic [WIDTH-1:0] r_rem, r_quo, r_div, r_result;
  logic [1:0]       r_op;
  logic             r_qSign, r_rSign;

  logic             w_signedOp, w_divZero, w_ovf, w_special, w_fits;
  logic [WIDTH-1:0] w_xMag, w_yMag, w_specialRes;
  logic [WIDTH:0]   w_remSh, w_diff;
  logic [WIDTH-1:0] w_remNext, w_quoNext, w_quoOut, w_remOut, w_final;

  assign w_signedOp   = ~op[0];
  assign w_divZero    = (Y == '0);
  assign w_ovf        = w_signedOp && (X == MinNeg) && (Y == '1);
  assign w_special    = w_divZero || w_ovf;
  assign w_xMag       = (w_signedOp && X[WIDTH-1]) ? -X : X;
  assign w_yMag       = (w_signedOp && Y[WIDTH-1]) ? -Y : Y;
  assign w_specialRes = w_divZero ? (op[1] ? X : '1) : (op[1] ? '0 : MinNeg);

  // The bit shifted out of the remainder is kept as bit 32 so large divisors
  // still compare correctly; a set carry always means the divisor fits.
  assign w_remSh   = {r_rem, r_quo[WIDTH-1]};
  assign w_diff    = w_remSh - {1'b0, r_div};
  assign w_fits    = w_remSh[WIDTH] | ~w_diff[WIDTH];
  assign w_remNext = w_fits ? w_diff[WIDTH-1:0] : w_remSh[WIDTH-1:0];
  assign w_quoNext = {r_quo[WIDTH-2:0], w_fits};

  assign w_quoOut = (r_op == 2'b00 && r_qSign) ? -w_quoNext : w_quoNext;
  assign w_remOut = (r_op == 2'b10 && r_rSign) ? -w_remNext : w_remNext;
  assign w_final  = r_op[1] ? w_remOut : w_quoOut;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = w_special ? DONE : CALC;
      CALC:    if (r_cnt == 5'd0) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_div    <= '0;
      r_result <= '0;
      r_op     <= '0;
      r_qSign  <= 1'b0;
      r_rSign  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_op    <= op;
            r_div   <= w_yMag;
            r_qSign <= w_signedOp & (X[WIDTH-1] ^ Y[WIDTH-1]);
            r_rSign <= w_signedOp & X[WIDTH-1];
            if (w_special) begin
              r_result <= w_specialRes;
            end else begin
              r_cnt <= 5'(WIDTH-1);
              r_rem <= '0;
              r_quo <= w_xMag;
            end
          end
        end
        CALC: begin
          r_rem <= w_remNext;
          r_quo <= w_quoNext;
          r_cnt <= r_cnt - 5'd1;
          if (r_cnt == 5'd0) r_result <= w_final;
        end
        default: ;
      endcase
    end
  end

  assign busy   = (r_state == CALC);
  assign done   = (r_state == DONE);
  assign result = r_result;

endmodule

// File: tb/tb_div32_iter.sv
// Self-checking bench for div32_iter: directed corner cases plus randomized
// operations checked against an arithmetic reference model.
module tb_div32_iter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] X = '0;
  logic [31:0] Y = '0;
  logic        busy, done;
  logic [31:0] result;

  int checkCount = 0;
  int failCount  = 0;
  int doneCount  = 0;
  int overlapCount = 0;

  div32_iter #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .X(X), .Y(Y),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) doneCount++;
    if (busy && done) overlapCount++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Division semantics straight from the operation definitions.
  function automatic logic [31:0] refModel(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, ux, uy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'({32'b0, x});
    uy = longint'({32'b0, y});
    if (y == 32'h0) return o[1] ? x : 32'hFFFF_FFFF;
    if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return o[1] ? 32'h0 : 32'h8000_0000;
    case (o)
      2'b00:   return 32'(sx / sy);
      2'b01:   return 32'(ux / uy);
      2'b10:   return 32'(sx % sy);
      default: return 32'(ux % uy);
    endcase
  endfunction

  function automatic bit isSpecial(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    return (y == 32'h0) || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF);
  endfunction

  // Issues one operation from a falling edge; lat counts rising edges from the
  // accepting edge up to the cycle where done is seen.
  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                               input int pulseAt, output logic [31:0] res, output int lat,
                               output int busyCnt, output logic doneAfter, output logic [31:0] resAfter);
    start = 1'b1; op = o; X = x; Y = y;
    @(posedge clk);
    lat = 1;
    busyCnt = 0;
    @(negedge clk);
    start = 1'b0;
    X = $urandom; Y = $urandom; op = 2'($urandom);
    while (!done && lat < 100) begin
      if (busy) busyCnt++;
      if (lat == pulseAt) begin
        start = 1'b1; X = 32'd9; Y = 32'd3; op = 2'b01;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    start = 1'b0;
    res = result;
    @(negedge clk);
    doneAfter = done;
    resAfter  = result;
  endtask

  task automatic runAndCheck(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] res, resAfter, exp;
    int lat, busyCnt;
    logic doneAfter;
    bit sp;
    exp = refModel(o, x, y);
    sp  = isSpecial(o, x, y);
    applyStimulus(o, x, y, 0, res, lat, busyCnt, doneAfter, resAfter);
    checkOutput({tag, " result"}, res, exp);
    checkOutput({tag, " latency"}, 32'(lat), sp ? 32'd1 : 32'd33);
    checkOutput({tag, " busyCycles"}, 32'(busyCnt), sp ? 32'd0 : 32'd32);
    checkOutput({tag, " donePulse"}, {31'b0, doneAfter}, 32'd0);
    checkOutput({tag, " resultHold"}, resAfter, exp);
  endtask

  initial begin
    logic [31:0] res, resAfter, x, y;
    logic [1:0]  o;
    int lat, busyCnt, startDone;
    logic doneAfter;

    repeat (3) @(negedge clk);
    checkOutput("reset busy", {31'b0, busy}, 32'd0);
    checkOutput("reset done", {31'b0, done}, 32'd0);
    checkOutput("reset result", result, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    runAndCheck("divu 100/7", 2'b01, 32'd100, 32'd7);
    runAndCheck("remu 100/7", 2'b11, 32'd100, 32'd7);
    runAndCheck("div -7/2", 2'b00, 32'hFFFF_FFF9, 32'd2);
    runAndCheck("rem -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2);
    runAndCheck("divu 5/0", 2'b01, 32'd5, 32'd0);
    runAndCheck("rem 5/0", 2'b10, 32'd5, 32'd0);
    runAndCheck("div ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
    runAndCheck("rem ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    runAndCheck("divu big", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    runAndCheck("remu big", 2'b11, 32'hFFFF_FFFE, 32'hFFFF_FFFF);

    // Start pulse during CALC must be ignored.
    startDone = doneCount;
    applyStimulus(2'b01, 32'd100, 32'd7, 5, res, lat, busyCnt, doneAfter, resAfter);
    repeat (40) @(negedge clk);
    checkOutput("ignored start result", res, 32'd14);
    checkOutput("ignored start latency", 32'(lat), 32'd33);
    checkOutput("ignored start doneCount", 32'(doneCount - startDone), 32'd1);
    checkOutput("ignored start hold", result, 32'd14);

    // Reset in the middle of CALC aborts the operation.
    start = 1'b1; op = 2'b01; X = 32'd100; Y = 32'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    checkOutput("pre-abort busy", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort busy", {31'b0, busy}, 32'd0);
    checkOutput("abort done", {31'b0, done}, 32'd0);
    checkOutput("abort result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    startDone = doneCount;
    repeat (40) @(negedge clk);
    checkOutput("abort no done", 32'(doneCount - startDone), 32'd0);
    checkOutput("abort result held", result, 32'd0);
    runAndCheck("divu ffffffff/16", 2'b01, 32'hFFFF_FFFF, 32'd16);

    for (int i = 0; i < 60; i++) begin
      o = 2'($urandom);
      x = $urandom;
      case ($urandom_range(0, 7))
        0:       y = 32'h0;
        1:       y = 32'($urandom_range(1, 20));
        2:       y = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        3: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        4:       y = $urandom >> $urandom_range(0, 31);
        default: y = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) x = x >> $urandom_range(0, 31);
      runAndCheck($sformatf("rand%0d op%0d", i, o), o, x, y);
    end

    checkOutput("busy/done overlap", 32'(overlapCount), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/div32_iter.md
DIV32_ITER -- requirements
Module: div32_iter

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width; only 32 is supported.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 start  input  1  request pulse; sampled only when the block is ready.
REQ-005 op  input  2  operation: 00 DIV (signed quotient), 01 DIVU, 10 REM (signed remainder), 11 REMU.
REQ-006 X  input  32  dividend; sampled with start.
REQ-007 Y  input  32  divisor; sampled with start.
REQ-008 busy  output  1  high while iterating (state CALC).
REQ-009 done  output  1  one-cycle completion pulse; result valid in the same cycle.
REQ-010 result  output  32  quotient or remainder; holds its value until the next completion.

Function
REQ-011 The block SHALL implement three states: IDLE, CALC and DONE.
REQ-012 Start SHALL be accepted only in IDLE; start in CALC or DONE SHALL be ignored, with no effect on operands or result.
REQ-013 On an accepted start at edge E0, the block SHALL register X, Y and op.
REQ-014 On the same edge it SHALL take operand magnitudes for signed ops and record the quotient sign (X[31]^Y[31]) and the remainder sign (X[31]).
REQ-015 Divide-by-zero (Y==0) at accept SHALL go IDLE->DONE at E0.
REQ-016 Divide-by-zero result: all-ones for DIV/DIVU; X for REM/REMU.
REQ-017 Signed overflow (op DIV or REM, X==0x80000000, Y==0xFFFFFFFF) at accept SHALL go IDLE->DONE at E0.
REQ-018 Signed-overflow result: 0x80000000 for DIV; 0 for REM.
REQ-019 Otherwise an accepted start SHALL go IDLE->CALC at E0, with a 5-bit step counter at 31, partial remainder at 0 and quotient register at the dividend magnitude.
REQ-020 Each CALC edge SHALL perform one restoring step.
REQ-021 Restoring step: shift {rem,quo} left 1; form the 33-bit difference rem - divisor; if it is non-negative, load rem with the difference and set quo[0]=1, else leave rem and set quo[0]=0; decrement the counter.
REQ-022 The CALC edge with counter==0 (edge E0+32) SHALL move to DONE and load result with the sign-corrected quotient or remainder.
REQ-023 Sign correction: the quotient is two's-complement negated when the quotient sign is 1 (DIV only); the remainder is negated when the remainder sign is 1 (REM only).
REQ-024 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-025 Normal-op latency: done high in the cycle after E0+32.
REQ-026 Special-case latency: done high in the cycle after E0.
REQ-027 busy SHALL be 1 exactly in CALC.
REQ-028 busy and done SHALL never be high together.
REQ-029 Back-to-back operation: a new start is accepted in the IDLE cycle following DONE, at the earliest.
REQ-030 X, Y and op changing during CALC SHALL NOT affect the result.
REQ-031 All arithmetic SHALL be modulo 2^32, except the 33-bit trial subtraction.

Reset
REQ-032 rst_n low SHALL immediately force state IDLE, busy=0, done=0, result=0, counter=0 and all internal registers to 0.
REQ-033 Reset during CALC or DONE SHALL abort the operation; no done pulse SHALL follow, and result SHALL read 0.
REQ-034 Operation SHALL resume on the first rising edge after rst_n deasserts.

Verification
REQ-035 DIVU X=100 Y=7 -> result 14, done after 33 cycles; REMU with same operands -> 2.
REQ-036 DIV X=0xFFFFFFF9 (-7) Y=2 -> 0xFFFFFFFD (-3); REM with same operands -> 0xFFFFFFFF (-1).
REQ-037 DIVU X=5 Y=0 -> 0xFFFFFFFF; REM X=5 Y=0 -> 5; in both cases done one cycle after the start edge and busy never high.
REQ-038 DIV X=0x80000000 Y=0xFFFFFFFF -> 0x80000000; REM with same operands -> 0; both in one cycle.
REQ-039 Start DIVU 100/7, then pulse start with X=9 Y=3 on CALC cycle 5 -> result still 14, one done pulse only.
REQ-040 Assert rst_n low on CALC cycle 10 -> busy=0, done=0, result=0, no later done; then DIVU 0xFFFFFFFF/16 -> 0x0FFFFFFF.
